// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// master FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StRsp
  } axi_lite_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one command in, one AXI read or write out, one result back.
// Single outstanding transaction; all AXI outputs come straight from flops.
module axi4_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_W-1:0]     cmd_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  // write address channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [2:0]            AWPROT,
  // write data channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_W-1:0]     WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  // write response channel
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // read address channel
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [2:0]            ARPROT,
  // read data channel
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY,
  // status
  output logic                  busy
);

  axi_lite_state_e r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_bready, w_bready_nxt;
  logic                  r_rready, w_rready_nxt;
  logic                  r_aw_done, w_aw_done_nxt;
  logic                  r_w_done, w_w_done_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]            r_rsp_resp, w_rsp_resp_nxt;
  logic                  r_rsp_write, w_rsp_write_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_done_set, w_w_done_set;

  assign w_aw_hs = r_awvalid & AWREADY;
  assign w_w_hs  = r_wvalid & WREADY;
  assign w_b_hs  = r_bready & BVALID;
  assign w_ar_hs = r_arvalid & ARREADY;
  assign w_r_hs  = r_rready & RVALID;

  // AW and W complete independently; a handshake this cycle counts as done.
  assign w_aw_done_set = r_aw_done | w_aw_hs;
  assign w_w_done_set  = r_w_done | w_w_hs;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= StIdle;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_rsp_write <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_araddr    <= w_araddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_rready    <= w_rready_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_rsp_write <= w_rsp_write_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (cmd_valid) w_state_nxt = cmd_write ? StWrReq : StRdReq;
      StWrReq:  if (w_aw_done_set && w_w_done_set) w_state_nxt = StWrResp;
      StWrResp: if (w_b_hs) w_state_nxt = StRsp;
      StRdReq:  if (w_ar_hs) w_state_nxt = StRdData;
      StRdData: if (w_r_hs) w_state_nxt = StRsp;
      StRsp:    if (rsp_ready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_awaddr_nxt    = r_awaddr;
    w_araddr_nxt    = r_araddr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_arvalid_nxt   = r_arvalid;
    w_bready_nxt    = r_bready;
    w_rready_nxt    = r_rready;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_rsp_write_nxt = r_rsp_write;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          w_rsp_write_nxt = cmd_write;
          w_aw_done_nxt   = 1'b0;
          w_w_done_nxt    = 1'b0;
          if (cmd_write) begin
            w_awaddr_nxt  = cmd_addr;
            w_wdata_nxt   = cmd_wdata;
            w_wstrb_nxt   = cmd_wstrb;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_araddr_nxt  = cmd_addr;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      StWrReq: begin
        if (w_aw_hs) w_awvalid_nxt = 1'b0;
        if (w_w_hs)  w_wvalid_nxt  = 1'b0;
        w_aw_done_nxt = w_aw_done_set;
        w_w_done_nxt  = w_w_done_set;
        if (w_aw_done_set && w_w_done_set) w_bready_nxt = 1'b1;
      end
      StWrResp: begin
        if (w_b_hs) begin
          w_rsp_resp_nxt  = BRESP;
          w_rsp_rdata_nxt = '0;
          w_bready_nxt    = 1'b0;
        end
      end
      StRdReq: begin
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      StRdData: begin
        if (w_r_hs) begin
          w_rsp_rdata_nxt = RDATA;
          w_rsp_resp_nxt  = RRESP;
          w_rready_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign rsp_valid = (r_state == StRsp);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign rsp_write = r_rsp_write;

  assign AWADDR  = r_awaddr;
  assign AWVALID = r_awvalid;
  assign AWPROT  = PROT_DEFAULT;
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;
  assign WVALID  = r_wvalid;
  assign BREADY  = r_bready;
  assign ARADDR  = r_araddr;
  assign ARVALID = r_arvalid;
  assign ARPROT  = PROT_DEFAULT;
  assign RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: a delay-programmable AXI4-Lite slave
// plus a cycle-count model of when each handshake and the response must appear.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [31:0] RDATA = '0;
  logic [3:0]  WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_slave();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0;
    RVALID = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    clear_slave();
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  // One complete transaction against a slave that waits the given number of
  // cycles on each channel. Expected timing: request in cycle 1, each wait adds one.
  task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int aw_d, input int w_d, input int b_d,
                        input int ar_d, input int r_d, input int rsp_d,
                        input logic [1:0] resp, input logic [31:0] rdata, input bit pulse);
    int c = 0, aw_hs = -1, w_hs = -1, b_hs = -1, b_n = 0, ar_hs = -1, r_hs = -1;
    int rsp_seen = -1, m_cyc = -1, viol = 0, exp_rsp;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
    logic [31:0] s_rdata = '0, exp_rdata;
    logic [1:0]  s_resp = '0;
    logic        s_write = 1'b0;
    exp_rsp   = wr ? ((aw_d > w_d) ? aw_d : w_d) + 3 + b_d : 3 + ar_d + r_d;
    exp_rdata = wr ? 32'h0 : rdata;

    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;

    while (m_cyc < 0 && c < 200) begin
      @(posedge ACLK); #1; c++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) viol++;
      cmd_valid = pulse ? 1'($urandom_range(1, 0)) : 1'b0;
      cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
      BRESP = 2'($urandom); RRESP = 2'($urandom); RDATA = $urandom;
      rsp_ready = 1'b0;
      // write address / data
      if (AWVALID) begin
        if (!wr || aw_hs >= 0 || AWADDR !== addr) viol++;
        if (aw_cnt == aw_d) begin AWREADY = 1'b1; aw_hs = c; end
        aw_cnt++;
      end else if (aw_cnt > 0 && aw_hs < 0) viol++;
      if (WVALID) begin
        if (!wr || w_hs >= 0 || WDATA !== wdata || WSTRB !== wstrb) viol++;
        if (w_cnt == w_d) begin WREADY = 1'b1; w_hs = c; end
        w_cnt++;
      end else if (w_cnt > 0 && w_hs < 0) viol++;
      if (BREADY) begin
        if (!wr || aw_hs < 0 || w_hs < 0 || c <= aw_hs || c <= w_hs || b_hs >= 0) viol++;
        if (b_cnt == b_d) begin BVALID = 1'b1; BRESP = resp; b_hs = c; b_n++; end
        b_cnt++;
      end
      // read address / data
      if (ARVALID) begin
        if (wr || ar_hs >= 0 || ARADDR !== addr) viol++;
        if (ar_cnt == ar_d) begin ARREADY = 1'b1; ar_hs = c; end
        ar_cnt++;
      end else if (ar_cnt > 0 && ar_hs < 0) viol++;
      if (RREADY) begin
        if (wr || ar_hs < 0 || c <= ar_hs || r_hs >= 0) viol++;
        if (r_cnt == r_d) begin RVALID = 1'b1; RDATA = rdata; RRESP = resp; r_hs = c; end
        r_cnt++;
      end
      // response port
      if (rsp_valid) begin
        if (rsp_seen < 0) begin
          rsp_seen = c; s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
        end else if ({rsp_rdata, rsp_resp, rsp_write} !== {s_rdata, s_resp, s_write}) viol++;
        if (rsp_cnt == rsp_d) begin rsp_ready = 1'b1; m_cyc = c; cmd_valid = 1'b0; end
        rsp_cnt++;
      end else if (rsp_seen >= 0) viol++;
    end

    @(posedge ACLK); #1;
    clear_slave();
    n_cmp++;
    if (m_cyc < 0) begin
      n_err++; $display("FAIL %s timeout: no rsp handshake within %0d cycles", name, c);
      apply_reset();
      return;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s cmd_ready_after_rsp: got %b want 1", name, cmd_ready);
    end
    n_cmp++;
    if (rsp_seen != exp_rsp) begin
      n_err++; $display("FAIL %s rsp_cycle: got %0d want %0d", name, rsp_seen, exp_rsp);
    end
    n_cmp++;
    if ({s_rdata, s_resp, s_write} !== {exp_rdata, resp, wr}) begin
      n_err++;
      $display("FAIL %s rsp_fields: got rdata=%h resp=%b write=%b want rdata=%h resp=%b write=%b",
               name, s_rdata, s_resp, s_write, exp_rdata, resp, wr);
    end
    n_cmp++;
    if (wr) begin
      if (aw_hs != 1 + aw_d || w_hs != 1 + w_d || b_n != 1) begin
        n_err++;
        $display("FAIL %s write_hs: got aw=%0d w=%0d b_count=%0d want aw=%0d w=%0d b_count=1",
                 name, aw_hs, w_hs, b_n, 1 + aw_d, 1 + w_d);
      end
    end else begin
      if (ar_hs != 1 + ar_d || r_hs != 2 + ar_d + r_d) begin
        n_err++;
        $display("FAIL %s read_hs: got ar=%0d r=%0d want ar=%0d r=%0d",
                 name, ar_hs, r_hs, 1 + ar_d, 2 + ar_d + r_d);
      end
    end
    n_cmp++;
    if (viol != 0) begin
      n_err++; $display("FAIL %s protocol: got %0d violations want 0", name, viol);
    end
    n_cmp++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy, AWPROT, ARPROT} !== '0) begin
      n_err++;
      $display("FAIL %s idle_outputs: got aw=%b w=%b ar=%b b=%b r=%b rv=%b busy=%b want all 0",
               name, AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy} !== 7'b0 ||
        cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b ready=%b want 0000000 ready=1",
                        AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy, cmd_ready);
    end
    n_cmp++;
    if ({AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write, AWPROT, ARPROT} !== '0) begin
      n_err++; $display("FAIL reset_data: got awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h want 0",
                        AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata);
    end
  endtask

  task automatic test_write_basic();
    do_txn("write_basic", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0,
           2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_read_wait();
    do_txn("read_wait", 1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 5, 0,
           2'b10, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_write_order();
    do_txn("write_w_first", 1'b1, 32'h44, 32'h12345678, 4'h3, 3, 0, 1, 0, 0, 0,
           2'b01, 32'h0, 1'b0);
    do_txn("write_aw_first", 1'b1, 32'h48, 32'h87654321, 4'hC, 0, 3, 2, 0, 0, 0,
           2'b11, 32'h0, 1'b0);
  endtask

  task automatic test_rsp_backpressure();
    do_txn("rsp_hold", 1'b0, 32'h80, 32'h0, 4'h0, 0, 0, 0, 1, 0, 6,
           2'b00, 32'hA5A5_5A5A, 1'b1);
    do_txn("rsp_next", 1'b1, 32'h84, 32'h0BAD_F00D, 4'h5, 0, 0, 0, 0, 0, 0,
           2'b10, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_txn("back_to_back", 1'(i), 32'h100 + 32'(i * 4), $urandom, 4'hF, 0, 0, 0, 0, 0, 0,
             2'(i), $urandom, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_txn("pre_reset_read", 1'b0, 32'h200, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
           2'b01, 32'hFFFF_0001, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'h1111_2222;
    cmd_wstrb = 4'hF;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (AWVALID !== 1'b1 || WVALID !== 1'b1) begin
      n_err++; $display("FAIL mid_wr_req: got aw=%b w=%b want 1 1", AWVALID, WVALID);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    n_cmp++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy} !== 7'b0 ||
        cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_ctrl: got %b%b%b%b%b%b%b ready=%b want 0000000 ready=1",
                        AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy, cmd_ready);
    end
    n_cmp++;
    if ({AWADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write} !== '0) begin
      n_err++; $display("FAIL mid_reset_data: got awaddr=%h wdata=%h rdata=%h resp=%b want 0",
                        AWADDR, WDATA, rsp_rdata, rsp_resp);
    end
    ARESETn = 1'b1;
    do_txn("post_reset_read", 1'b0, 32'h204, 32'h0, 4'h0, 0, 0, 0, 2, 1, 1,
           2'b00, 32'h7777_8888, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
             int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
             int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
             2'($urandom), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_order();
    test_rsp_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
